div_sign_sequencer: RTL and testbench

Front-end/back-end controller for the team's 4-bit restoring divider (start held high until done pulse; unsigned quotient/remainder out). Accepts signed 4-bit operand pairs on a valid/ready interface and converts them to magnitudes. Drives the divider's start_sig, captures its result on the done pulse, and re-applies signs with C semantics: quotient truncates toward zero, remainder takes the dividend's sign. Illegal operands and a hung divider are handled locally and reported as errors.

---
 rtl/div_seq_pkg.sv | 20 ++
 rtl/div_sign_sequencer_if.sv | 39 +++
 rtl/div_sign_fix.sv | 22 ++
 rtl/div_sign_sequencer.sv | 160 ++++++++++++++++
 tb/tb_div_sign_sequencer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/div_seq_pkg.sv
// Shared types and constants for the signed front/back-end of the 4-bit restoring divider.
package div_seq_pkg;

    localparam int DEF_W           = 4;
    localparam int DEF_TIMEOUT_CYC = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2,
        DEAD = 2'd3
    } state_t;

    function automatic int unsigned most_neg_of(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    localparam logic [DEF_W-1:0] MOST_NEG = DEF_W'(most_neg_of(DEF_W));

endpackage

// File: rtl/div_sign_sequencer_if.sv
// Operand, divider and result signals of div_sign_sequencer; slave is the sequencer side.
interface div_sign_sequencer_if
    import div_seq_pkg::*;
#(
    parameter int W = DEF_W
);
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_dividend;
    logic signed [W-1:0] in_divisor;
    logic                div_start;
    logic                div_done;
    logic        [W-1:0] div_quotient;
    logic        [W-1:0] div_remainder;
    logic        [W-1:0] div_dividend;
    logic        [W-1:0] div_divisor;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_quotient;
    logic signed [W-1:0] out_remainder;
    logic                out_err;
    logic                stuck;

    modport slave (
        input  in_valid, in_dividend, in_divisor,
        input  div_done, div_quotient, div_remainder,
        input  out_ready,
        output in_ready, div_start, div_dividend, div_divisor,
        output out_valid, out_quotient, out_remainder, out_err, stuck
    );

    modport master (
        output in_valid, in_dividend, in_divisor,
        output div_done, div_quotient, div_remainder,
        output out_ready,
        input  in_ready, div_start, div_dividend, div_divisor,
        input  out_valid, out_quotient, out_remainder, out_err, stuck
    );
endinterface

// File: rtl/div_sign_fix.sv
// Magnitude conversion of signed operands and C-style sign re-application of the unsigned result.
module div_sign_fix #(
    parameter int W = 4
) (
    input  logic signed [W-1:0] dividend,
    input  logic signed [W-1:0] divisor,
    input  logic                sign_a,
    input  logic                sign_b,
    input  logic        [W-1:0] udiv_q,
    input  logic        [W-1:0] udiv_r,
    output logic        [W-1:0] mag_a,
    output logic        [W-1:0] mag_b,
    output logic signed [W-1:0] res_q,
    output logic signed [W-1:0] res_r
);
    assign mag_a = dividend[W-1] ? -dividend : dividend;
    assign mag_b = divisor[W-1]  ? -divisor  : divisor;

    // Quotient truncates toward zero; remainder follows the dividend's sign.
    assign res_q = (sign_a ^ sign_b) ? -signed'(udiv_q) : signed'(udiv_q);
    assign res_r = sign_a            ? -signed'(udiv_r) : signed'(udiv_r);
endmodule

// File: rtl/div_sign_sequencer.sv
// Signed valid/ready wrapper around the unsigned restoring divider with hang detection.
// Optional macro DIV_SEQ_STATS_EN adds saturating delivered-result counters stat_ops/stat_errs.
module div_sign_sequencer
    import div_seq_pkg::*;
#(
    parameter int W           = DEF_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                 clk,
    input  logic                 rst,
    div_sign_sequencer_if.slave  bus
`ifdef DIV_SEQ_STATS_EN
    ,
    output logic [15:0]          stat_ops,
    output logic [15:0]          stat_errs
`endif
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [W-1:0] NEG_LIM = W'(most_neg_of(W));

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [W-1:0]        op_a_q, op_a_d, op_b_q, op_b_d;
    logic                start_q, start_d, err_q, err_d, stuck_q, stuck_d;
    logic signed [W-1:0] quo_q, quo_d, rem_q, rem_d;
    logic [W-1:0]        mag_a, mag_b;
    logic signed [W-1:0] fix_q, fix_r;
    logic                accept, illegal;

    div_sign_fix #(.W(W)) u_fix (
        .dividend (bus.in_dividend),
        .divisor  (bus.in_divisor),
        .sign_a   (sign_a_q),
        .sign_b   (sign_b_q),
        .udiv_q   (bus.div_quotient),
        .udiv_r   (bus.div_remainder),
        .mag_a    (mag_a),
        .mag_b    (mag_b),
        .res_q    (fix_q),
        .res_r    (fix_r)
    );

    assign bus.in_ready      = (state_q == IDLE) && !rst;
    assign bus.out_valid     = (state_q == HOLD);
    assign bus.div_start     = start_q;
    assign bus.div_dividend  = op_a_q;
    assign bus.div_divisor   = op_b_q;
    assign bus.out_quotient  = quo_q;
    assign bus.out_remainder = rem_q;
    assign bus.out_err       = err_q;
    assign bus.stuck         = stuck_q;

    assign accept  = bus.in_valid && bus.in_ready;
    // Zero divisor and the unnegatable most-negative value never reach the divider.
    assign illegal = (bus.in_divisor == '0) || (bus.in_dividend == NEG_LIM) ||
                     (bus.in_divisor == NEG_LIM);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        start_d  = start_q;
        err_d    = err_q;
        stuck_d  = stuck_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sign_a_d = bus.in_dividend[W-1];
                    sign_b_d = bus.in_divisor[W-1];
                    if (illegal) begin
                        err_d   = 1'b1;
                        quo_d   = '0;
                        rem_d   = '0;
                        state_d = HOLD;
                    end else begin
                        op_a_d  = mag_a;
                        op_b_d  = mag_b;
                        start_d = 1'b1;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                // start must drop on the done edge or the divider begins another pass.
                if (bus.div_done) begin
                    start_d = 1'b0;
                    quo_d   = fix_q;
                    rem_d   = fix_r;
                    err_d   = 1'b0;
                    state_d = HOLD;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    start_d = 1'b0;
                    err_d   = 1'b1;
                    quo_d   = '0;
                    rem_d   = '0;
                    stuck_d = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (bus.out_ready) state_d = stuck_q ? DEAD : IDLE;
            end
            DEAD: state_d = DEAD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            start_q  <= 1'b0;
            err_q    <= 1'b0;
            stuck_q  <= 1'b0;
            quo_q    <= '0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            start_q  <= start_d;
            err_q    <= err_d;
            stuck_q  <= stuck_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
        end
    end

`ifdef DIV_SEQ_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops  <= '0;
            stat_errs <= '0;
        end else if (bus.out_valid && bus.out_ready) begin
            if (err_q) stat_errs <= sat_inc(stat_errs);
            else       stat_ops  <= sat_inc(stat_ops);
        end
    end
`endif
endmodule

// File: tb/tb_div_sign_sequencer.sv
// Bench for div_sign_sequencer with a behavioural 8-cycle divider and a C-semantics reference model.
module tb_div_sign_sequencer;
    import div_seq_pkg::*;

    localparam int TMO = DEF_TIMEOUT_CYC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   hang = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [3:0] exp_q, exp_r;
    logic       exp_e, exp_stuck;
    int         exp_lat;

    div_sign_sequencer_if #(.W(DEF_W)) bus ();

`ifdef DIV_SEQ_STATS_EN
    logic [15:0] stat_ops, stat_errs;
    int          exp_ops = 0, exp_errs = 0;
    div_sign_sequencer dut (.clk(clk), .rst(rst), .bus(bus),
                            .stat_ops(stat_ops), .stat_errs(stat_errs));
`else
    div_sign_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    // Divider model: start held high, one-cycle done pulse sampled 8 edges after start rises.
    logic [3:0] dcnt;
    logic       ddone;
    always @(posedge clk) begin
        if (rst) begin
            dcnt  <= '0;
            ddone <= 1'b0;
        end else if (bus.div_start && !hang) begin
            if (ddone) begin
                ddone <= 1'b0;
                dcnt  <= '0;
            end else begin
                dcnt <= dcnt + 4'd1;
                if (dcnt == 4'd6) ddone <= 1'b1;
            end
        end else begin
            dcnt  <= '0;
            ddone <= 1'b0;
        end
    end
    assign bus.div_done      = ddone;
    assign bus.div_quotient  = (bus.div_divisor != 0) ? bus.div_dividend / bus.div_divisor : 4'd0;
    assign bus.div_remainder = (bus.div_divisor != 0) ? bus.div_dividend % bus.div_divisor : 4'd0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [3:0] ab, input logic [3:0] bb,
                                  output logic [3:0] q, output logic [3:0] r, output logic e);
        int a, b;
        a = $signed(ab);
        b = $signed(bb);
        if (b == 0 || ab == MOST_NEG || bb == MOST_NEG) begin
            e = 1'b1; q = '0; r = '0;
        end else begin
            e = 1'b0; q = 4'(a / b); r = 4'(a % b);
        end
    endfunction

    task automatic start_op(input logic [3:0] a, input logic [3:0] b);
        int   lat;
        logic prev_start;
        model(a, b, exp_q, exp_r, exp_e);
        exp_lat = exp_e ? 0 : 8;
        if (!exp_e && hang) begin
            exp_e = 1'b1; exp_q = '0; exp_r = '0; exp_lat = TMO; exp_stuck = 1'b1;
        end
        chk("ready_before", bus.in_ready, 1'b1);
        bus.in_valid    = 1'b1;
        bus.in_dividend = a;
        bus.in_divisor  = b;
        tick();
        bus.in_valid = 1'b0;
        chk("ready_after_accept", bus.in_ready, 1'b0);
        lat = 0;
        prev_start = bus.div_start;
        while (!bus.out_valid && lat < 40) begin
            prev_start = bus.div_start;
            tick();
            lat++;
        end
        chk("latency", 16'(lat), 16'(exp_lat));
        chk("start_before_done", prev_start, exp_lat != 0);
        chk("start_low_at_result", bus.div_start, 1'b0);
        chk("quotient", bus.out_quotient[3:0], exp_q);
        chk("remainder", bus.out_remainder[3:0], exp_r);
        chk("err", bus.out_err, exp_e);
        chk("stuck", bus.stuck, exp_stuck);
    endtask

    task automatic finish_op();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
`ifdef DIV_SEQ_STATS_EN
        if (exp_e) exp_errs++; else exp_ops++;
`endif
        chk("valid_drop", bus.out_valid, 1'b0);
        chk("ready_after_handshake", bus.in_ready, !exp_stuck);
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_dividend = '0;
        bus.in_divisor  = '0;
        bus.out_ready   = 1'b0;
        exp_stuck       = 1'b0;

        tick();
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_div_start", bus.div_start, 1'b0);
        chk("rst_quotient", bus.out_quotient[3:0], 4'h0);
        chk("rst_remainder", bus.out_remainder[3:0], 4'h0);
        chk("rst_err", bus.out_err, 1'b0);
        chk("rst_stuck", bus.stuck, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1'b1);

        start_op(4'd7, 4'd2);   finish_op();
        start_op(4'h9, 4'd2);   finish_op();
        start_op(4'd7, 4'hE);   finish_op();
        start_op(4'hA, 4'hD);   finish_op();
        start_op(4'd5, 4'd0);   finish_op();
        start_op(4'h8, 4'd3);   finish_op();
        start_op(4'd3, 4'h8);   finish_op();

        // Result held while downstream stalls; new operands are not taken.
        start_op(4'd7, 4'd3);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid    = 1'b1;
            bus.in_dividend = 4'd3;
            bus.in_divisor  = 4'd1;
            tick();
            chk("stall_valid", bus.out_valid, 1'b1);
            chk("stall_in_ready", bus.in_ready, 1'b0);
            chk("stall_quotient", bus.out_quotient[3:0], exp_q);
            chk("stall_remainder", bus.out_remainder[3:0], exp_r);
        end
        bus.in_valid = 1'b0;
        finish_op();
        start_op(4'd6, 4'hD);   finish_op();

        for (int n = 0; n < 40; n++) begin
            start_op(4'($urandom_range(15)), 4'($urandom_range(15)));
            repeat ($urandom_range(2)) begin
                tick();
                chk("rand_hold_valid", bus.out_valid, 1'b1);
            end
            finish_op();
        end

        // Hung divider: timeout, then locked out until reset.
        hang = 1'b1;
        start_op(4'd5, 4'd2);
        finish_op();
        bus.in_valid = 1'b1;
        repeat (3) begin
            tick();
            chk("dead_in_ready", bus.in_ready, 1'b0);
            chk("dead_valid", bus.out_valid, 1'b0);
        end
        bus.in_valid = 1'b0;
        hang = 1'b0;
        rst  = 1'b1;
        tick();
        rst = 1'b0;
        exp_stuck = 1'b0;
        #1;
        chk("recover_stuck", bus.stuck, 1'b0);
        chk("recover_in_ready", bus.in_ready, 1'b1);

        // Reset in the middle of a division discards it.
        bus.in_valid    = 1'b1;
        bus.in_dividend = 4'd7;
        bus.in_divisor  = 4'd2;
        tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        chk("busy_start", bus.div_start, 1'b1);
        rst = 1'b1;
        tick();
        chk("midrst_start", bus.div_start, 1'b0);
        chk("midrst_valid", bus.out_valid, 1'b0);
        chk("midrst_in_ready", bus.in_ready, 1'b0);
        chk("midrst_quotient", bus.out_quotient[3:0], 4'h0);
        rst = 1'b0;
        #1;
`ifdef DIV_SEQ_STATS_EN
        exp_ops  = 0;
        exp_errs = 0;
`endif
        start_op(4'd6, 4'd4);   finish_op();
        chk("fresh_quotient", bus.out_quotient[3:0], 4'd1);
        chk("fresh_remainder", bus.out_remainder[3:0], 4'd2);

`ifdef DIV_SEQ_STATS_EN
        chk("stat_ops", stat_ops, 16'(exp_ops));
        chk("stat_errs", stat_errs, 16'(exp_errs));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
